// File: rtl/cdc_hs_arbiter.sv
// Source side of a shared 4-phase req/ack CDC channel: round-robin picks one
// local requester, registers its payload, and sequences req/ack with abort on timeout.
module cdc_hs_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*DATA_W-1:0]    i_data,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [N_REQ-1:0]           o_timeout,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_owner,
    output logic                       o_xfer_req,
    output logic [DATA_W-1:0]          o_xfer_data,
    input  logic                       i_xfer_ack
);

    localparam int unsigned OWN_W    = $clog2(N_REQ);
    localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [CNT_W-1:0] CNT_LAST_V = CNT_W'(CNT_LAST);
    localparam logic [OWN_W-1:0] OWN_MAX    = OWN_W'(N_REQ - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACK_WAIT = 2'd1;
    localparam logic [1:0] S_REL_WAIT = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [OWN_W-1:0]  owner_q,     owner_d;
    logic [OWN_W-1:0]  ptr_q,       ptr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              xfer_req_q,  xfer_req_d;
    logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
    logic [N_REQ-1:0]  gnt_q,       gnt_d;
    logic [N_REQ-1:0]  tmo_q,       tmo_d;
    logic              busy_q,      busy_d;

    logic              hi_found, lo_found;
    logic [OWN_W-1:0]  hi_idx, lo_idx, win_idx;
    logic [DATA_W-1:0] win_data;
    logic [OWN_W-1:0]  next_ptr;
    logic [N_REQ-1:0]  owner_oh;
    logic              tmo_hit;

    // Round-robin search: lowest active index at/above the pointer, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (i_req[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = OWN_W'(k);
            end
            if (i_req[k] && !hi_found && (k >= 32'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = OWN_W'(k);
            end
        end
        win_idx  = hi_found ? hi_idx : lo_idx;
        win_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (OWN_W'(k) == win_idx) begin
                win_data = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        next_ptr = (owner_q == OWN_MAX) ? '0 : owner_q + OWN_W'(1);
        owner_oh = N_REQ'(1) << owner_q;
        tmo_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST_V);
    end

    // Handshake sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
        gnt_d       = '0;
        tmo_d       = '0;

        case (state_q)
            S_IDLE: begin
                // A stale high ack from the far side must clear before a new transfer.
                if ((|i_req) && !i_xfer_ack) begin
                    owner_d     = win_idx;
                    xfer_data_d = win_data;
                    xfer_req_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_ACK_WAIT;
                end
            end
            S_ACK_WAIT: begin
                if (i_xfer_ack) begin
                    xfer_req_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_REL_WAIT;
                end else if (tmo_hit) begin
                    xfer_req_d = 1'b0;
                    tmo_d      = owner_oh;
                    ptr_d      = next_ptr;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REL_WAIT: begin
                if (!i_xfer_ack) begin
                    gnt_d   = owner_oh;
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_d   = owner_oh;
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                xfer_req_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            gnt_q       <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            gnt_q       <= gnt_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_timeout   = tmo_q;
    assign o_busy      = busy_q;
    assign o_owner     = owner_q;
    assign o_xfer_req  = xfer_req_q;
    assign o_xfer_data = xfer_data_q;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Scoreboard bench for cdc_hs_arbiter: expected completions are queued when
// requests are driven and popped when a grant/timeout pulse appears.
module tb_cdc_hs_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic [N_REQ-1:0]        o_gnt;
    logic [N_REQ-1:0]        o_timeout;
    logic                    o_busy;
    logic [1:0]              o_owner;
    logic                    o_xfer_req;
    logic [DATA_W-1:0]       o_xfer_data;
    logic                    i_xfer_ack;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] tmo;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cdc_hs_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (i_req),
        .i_data      (i_data),
        .o_gnt       (o_gnt),
        .o_timeout   (o_timeout),
        .o_busy      (o_busy),
        .o_owner     (o_owner),
        .o_xfer_req  (o_xfer_req),
        .o_xfer_data (o_xfer_data),
        .i_xfer_ack  (i_xfer_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        i_req      = '0;
        i_xfer_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_xreq(input logic lvl, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max_cyc; i++) begin
            if (!ok) begin
                if (o_xfer_req === lvl) ok = 1'b1;
                else if (i < max_cyc) tick();
            end
        end
    endtask

    task automatic wait_pulse(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max_cyc; i++) begin
            if (!ok) begin
                if ((|o_gnt) || (|o_timeout)) ok = 1'b1;
                else if (i < max_cyc) tick();
            end
        end
    endtask

    // Far side: raise ack, wait for req to fall, release ack, wait for the pulse.
    task automatic far_handshake(input int dly, output bit ok);
        bit ok1;
        bit ok2;
        repeat (dly) tick();
        i_xfer_ack = 1'b1;
        wait_xreq(1'b0, 6, ok1);
        i_xfer_ack = 1'b0;
        wait_pulse(6, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        i_req      = 4'hF;
        i_xfer_ack = 1'b0;
        i_data     = 32'hFFFF_FFFF;
        tick();
        tick();
        n_checks++;
        if ({o_gnt, o_timeout, o_busy, o_owner, o_xfer_req, o_xfer_data} !== 20'h0)
            $display("FAIL reset_outputs: got gnt=%b tmo=%b busy=%b owner=%0d req=%b data=%h, expected all zero",
                     o_gnt, o_timeout, o_busy, o_owner, o_xfer_req, o_xfer_data);
        else n_pass++;
        i_req = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        apply_reset();
        i_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        i_req  = 4'b0100;
        exp_q.push_back({4'b0100, 4'b0000, 8'hA5});
        tick();
        n_checks++;
        if ({o_xfer_req, o_busy, o_owner, o_xfer_data} !== {1'b1, 1'b1, 2'd2, 8'hA5})
            $display("FAIL single_grant: got req=%b busy=%b owner=%0d data=%h, expected req=1 busy=1 owner=2 data=a5",
                     o_xfer_req, o_busy, o_owner, o_xfer_data);
        else n_pass++;
        i_data[23:16] = 8'h00;
        tick();
        tick();
        i_xfer_ack = 1'b1;
        tick();
        n_checks++;
        if ({o_xfer_req, o_busy, o_xfer_data} !== {1'b0, 1'b1, 8'hA5})
            $display("FAIL single_req_fall: got req=%b busy=%b data=%h, expected req=0 busy=1 data=a5",
                     o_xfer_req, o_busy, o_xfer_data);
        else n_pass++;
        tick();
        tick();
        i_xfer_ack = 1'b0;
        tick();
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL single_scoreboard: got empty queue, expected an entry");
        else begin
            e = exp_q.pop_front();
            if ({o_gnt, o_timeout, o_xfer_data} !== e)
                $display("FAIL single_gnt: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h",
                         o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data);
            else n_pass++;
        end
        i_req = '0;
        tick();
        n_checks++;
        if ({o_gnt, o_busy, o_xfer_req} !== 6'b0)
            $display("FAIL single_after: got gnt=%b busy=%b req=%b, expected all zero", o_gnt, o_busy, o_xfer_req);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({o_gnt, o_timeout, o_xfer_req} !== 9'b0)
            $display("FAIL single_quiet: got gnt=%b tmo=%b req=%b, expected all zero", o_gnt, o_timeout, o_xfer_req);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        apply_reset();
        i_data = {8'hD3, 8'hA5, 8'h5C, 8'h3E};
        i_req  = 4'hF;
        for (int k = 0; k < 4; k++) exp_q.push_back({4'b0001 << k, 4'b0000, i_data[k*8 +: 8]});
        for (int n = 0; n < 5; n++) begin
            wait_xreq(1'b1, 4, ok);
            n_checks++;
            if (!ok) $display("FAIL rr_req_rise: got req=%b after 4 cycles, expected 1 (xfer %0d)", o_xfer_req, n);
            else n_pass++;
            far_handshake(2, ok);
            n_checks++;
            if (!ok || exp_q.size() == 0)
                $display("FAIL rr_handshake: got ok=%b queue=%0d, expected completion pulse (xfer %0d)", ok, exp_q.size(), n);
            else begin
                e = exp_q.pop_front();
                if ({o_gnt, o_timeout, o_xfer_data} !== e)
                    $display("FAIL rr_gnt: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h (xfer %0d)",
                             o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data, n);
                else n_pass++;
            end
            if (n == 3) begin
                i_req = 4'b1001;
                exp_q.push_back({4'b0001, 4'b0000, 8'h3E});
            end
            if (n == 4) i_req = '0;
            if (n < 4) begin
                tick();
                n_checks++;
                if (o_xfer_req !== 1'b1)
                    $display("FAIL rr_back_to_back: got req=%b, expected 1 one cycle after pulse (xfer %0d)", o_xfer_req, n);
                else n_pass++;
            end
        end
        tick();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL rr_idle: got busy=%b, expected 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_ack_timeout();
        exp_t e;
        bit   ok;
        int   hi;
        i_req = 4'b0010;
        exp_q.push_back({4'b0000, 4'b0010, 8'h5C});
        tick();
        hi = 0;
        while (o_xfer_req === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        n_checks++;
        if (hi != 8) $display("FAIL tmo_req_width: got %0d cycles high, expected 8", hi);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL tmo_scoreboard: got empty queue, expected an entry");
        else begin
            e = exp_q.pop_front();
            if ({o_gnt, o_timeout, o_xfer_data} !== e)
                $display("FAIL tmo_pulse: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h",
                         o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data);
            else n_pass++;
        end
        i_req = 4'b0111;
        exp_q.push_back({4'b0100, 4'b0000, 8'hA5});
        tick();
        n_checks++;
        if ({o_xfer_req, o_owner} !== {1'b1, 2'd2})
            $display("FAIL tmo_ptr_advance: got req=%b owner=%0d, expected req=1 owner=2", o_xfer_req, o_owner);
        else n_pass++;
        far_handshake(1, ok);
        n_checks++;
        if (!ok || exp_q.size() == 0) $display("FAIL tmo_followup: got ok=%b queue=%0d, expected pulse", ok, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({o_gnt, o_timeout, o_xfer_data} !== e)
                $display("FAIL tmo_followup_gnt: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h",
                         o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data);
            else n_pass++;
        end
        i_req = '0;
        tick();
    endtask

    task automatic test_stuck_ack();
        exp_t e;
        bit   ok;
        apply_reset();
        i_xfer_ack = 1'b1;
        i_req      = 4'b0001;
        exp_q.push_back({4'b0001, 4'b0000, 8'h3E});
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({o_xfer_req, o_busy, o_gnt} !== 6'b0)
                $display("FAIL stuck_blocked: got req=%b busy=%b gnt=%b, expected all zero (cycle %0d)",
                         o_xfer_req, o_busy, o_gnt, i);
            else n_pass++;
        end
        i_xfer_ack = 1'b0;
        tick();
        n_checks++;
        if ({o_xfer_req, o_owner} !== {1'b1, 2'd0})
            $display("FAIL stuck_release: got req=%b owner=%0d, expected req=1 owner=0", o_xfer_req, o_owner);
        else n_pass++;
        far_handshake(1, ok);
        n_checks++;
        if (!ok || exp_q.size() == 0) $display("FAIL stuck_complete: got ok=%b queue=%0d, expected pulse", ok, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({o_gnt, o_timeout, o_xfer_data} !== e)
                $display("FAIL stuck_gnt: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h",
                         o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data);
            else n_pass++;
        end
        i_req = '0;
        tick();
    endtask

    task automatic test_reset_midop();
        exp_t e;
        bit   ok;
        i_req = 4'b0100;
        tick();
        i_xfer_ack = 1'b1;
        tick();
        n_checks++;
        if ({o_busy, o_xfer_req, o_owner} !== {1'b1, 1'b0, 2'd2})
            $display("FAIL rstmid_setup: got busy=%b req=%b owner=%0d, expected busy=1 req=0 owner=2",
                     o_busy, o_xfer_req, o_owner);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({o_xfer_req, o_busy, o_owner, o_gnt, o_timeout} !== 12'b0)
            $display("FAIL rstmid_clear: got req=%b busy=%b owner=%0d gnt=%b tmo=%b, expected all zero",
                     o_xfer_req, o_busy, o_owner, o_gnt, o_timeout);
        else n_pass++;
        i_xfer_ack = 1'b0;
        rst_n      = 1'b1;
        i_req      = 4'hF;
        exp_q.push_back({4'b0001, 4'b0000, 8'h3E});
        tick();
        n_checks++;
        if ({o_xfer_req, o_owner} !== {1'b1, 2'd0})
            $display("FAIL rstmid_restart: got req=%b owner=%0d, expected req=1 owner=0", o_xfer_req, o_owner);
        else n_pass++;
        far_handshake(1, ok);
        n_checks++;
        if (!ok || exp_q.size() == 0) $display("FAIL rstmid_complete: got ok=%b queue=%0d, expected pulse", ok, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({o_gnt, o_timeout, o_xfer_data} !== e)
                $display("FAIL rstmid_gnt: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h",
                         o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data);
            else n_pass++;
        end
        i_req = '0;
        tick();
    endtask

    task automatic test_req_drop();
        exp_t e;
        bit   ok;
        i_req = 4'b0010;
        exp_q.push_back({4'b0010, 4'b0000, 8'h5C});
        tick();
        n_checks++;
        if ({o_xfer_req, o_owner} !== {1'b1, 2'd1})
            $display("FAIL drop_grant: got req=%b owner=%0d, expected req=1 owner=1", o_xfer_req, o_owner);
        else n_pass++;
        i_req = '0;
        far_handshake(2, ok);
        n_checks++;
        if (!ok || exp_q.size() == 0) $display("FAIL drop_complete: got ok=%b queue=%0d, expected pulse", ok, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({o_gnt, o_timeout, o_xfer_data} !== e)
                $display("FAIL drop_gnt: got gnt=%b tmo=%b data=%h, expected gnt=%b tmo=%b data=%h",
                         o_gnt, o_timeout, o_xfer_data, e.gnt, e.tmo, e.data);
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({o_busy, o_xfer_req, o_gnt} !== 6'b0)
            $display("FAIL drop_idle: got busy=%b req=%b gnt=%b, expected all zero", o_busy, o_xfer_req, o_gnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ack_timeout();
        test_stuck_ack();
        test_reset_midop();
        test_req_drop();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdc_hs_arbiter.md
Name: cdc_hs_arbiter

Overview:
- Source-side controller for one shared 4-phase req/ack clock-domain-crossing channel.
- Round-robin arbitrates N_REQ local requesters and registers the winner's data onto a single crossing bus.
- Sequences the handshake: req up, wait ack up, req down, wait ack down.
- i_xfer_ack arrives already synchronized into i_clk by a 2-stage synchronizer instance outside this block; the far side synchronizes o_xfer_req and samples o_xfer_data once its req is seen high.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 8, payload width per requester.
- TIMEOUT, 255, max consecutive cycles spent in a wait state before abort; 0 disables the timeout.

Ports:
- i_clk  in  1  block clock.
- i_rst_n  in  1  reset, synchronous to i_clk, active-low.
- i_req  in  N_REQ  per-requester transfer request; level, held until o_gnt or o_timeout.
- i_data  in  N_REQ*DATA_W  payloads; slice k = i_data[k*DATA_W +: DATA_W].
- o_gnt  out  N_REQ  one-hot 1-cycle pulse: owner's transfer completed.
- o_timeout  out  N_REQ  one-hot 1-cycle pulse: owner's transfer aborted.
- o_busy  out  1  high whenever FSM is not IDLE.
- o_owner  out  $clog2(N_REQ)  index of the current/last granted requester.
- o_xfer_req  out  1  4-phase request to the far domain, registered.
- o_xfer_data  out  DATA_W  payload, registered, stable while o_xfer_req=1.
- i_xfer_ack  in  1  far-domain ack, already synchronized to i_clk.

Behaviour:
- Reset (i_rst_n=0 at a posedge):
  - FSM=IDLE; all outputs 0; o_owner=0; rr pointer=0; timeout counter=0.
  - Applies mid-handshake too: o_xfer_req drops the next edge, with no o_gnt or o_timeout.
- FSM states: IDLE, ACK_WAIT, REL_WAIT.
- IDLE:
  - Arbitrates only if |i_req and i_xfer_ack==0. Any leftover high ack blocks new grants.
  - Winner = first k with i_req[k]=1, searching from the pointer upward with wrap to 0.
  - On the edge: o_owner<=k, o_xfer_data<=slice k, o_xfer_req<=1, cnt<=0, go ACK_WAIT.
- ACK_WAIT:
  - If i_xfer_ack=1: o_xfer_req<=0, cnt<=0, go REL_WAIT.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1: o_xfer_req<=0, o_timeout[o_owner]<=1, pointer<=o_owner+1 (mod N_REQ), go IDLE.
  - Else cnt<=cnt+1.
- REL_WAIT:
  - If i_xfer_ack=0: o_gnt[o_owner]<=1, pointer<=o_owner+1 (mod N_REQ), go IDLE.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1: o_timeout[o_owner]<=1, pointer advances as above, go IDLE.
  - Else cnt<=cnt+1.
- Latency:
  - i_req seen in IDLE at edge t: o_xfer_req=1 after t.
  - Ack high sampled at edge a: o_xfer_req=0 after a.
  - Ack low sampled at edge r: o_gnt pulse for the cycle after r.
  - Back-to-back: the next o_xfer_req rises one edge after the o_gnt pulse edge, i.e. a minimum of 1 IDLE cycle between transfers.
- Data and request rules:
  - o_xfer_data changes only on the IDLE->ACK_WAIT edge, so it is stable through the whole handshake.
  - i_data is sampled once; later changes are ignored.
  - Dropping i_req mid-transfer does not abort it; o_gnt still pulses.
  - Requests arriving in non-IDLE states wait.
- Fairness: the pointer advances only on completion or abort. With all requesters active, the grant order is 0,1,2,3,0...
- Pulses: o_gnt and o_timeout are never both set in a cycle, and each is at most one-hot.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit; it never wraps.
- o_busy=1 in ACK_WAIT and REL_WAIT.

Test Plan:
- Single transfer: reset, i_req=4'b0100, slice2=8'hA5; ack rises 3 cycles after req and falls 2 cycles after req drops. Expect o_xfer_req=1 one edge after i_req, o_xfer_data=8'hA5, o_owner=2, exactly one o_gnt=4'b0100 pulse, o_busy low afterwards.
- Round-robin: i_req=4'hF held, far-side model acks every transfer. Expect o_gnt order 0,1,2,3,0 with o_xfer_data matching each slice; then i_req=4'b1001 after owner 3 completes -> next owner 0.
- Ack timeout: TIMEOUT=8, ack never rises. Expect o_xfer_req high exactly 8 cycles, o_timeout=owner pulse, no o_gnt, pointer advanced.
- Stuck ack: ack held 1 in IDLE with i_req=4'b0001. Expect no grant and o_xfer_req=0 until ack=0, then grant on the next edge.
- Reset mid-op: assert i_rst_n=0 during REL_WAIT. Expect next edge o_xfer_req=0, o_busy=0, o_owner=0, no pulses; after release, grant order restarts at requester 0.
- Requester drop: i_req[1] deasserted during ACK_WAIT. Expect the transfer to complete with o_gnt=4'b0010.
